lfsr_multimode: RTL and testbench
=================================

# lfsr_multimode

Parametrised LFSR engine that succeeds the fixed 16-bit Fibonacci generator: runtime-selectable length, user-supplied tap mask, Fibonacci or Galois topology, seed load, and a period counter that reports the sequence length on wrap. It sits between the tile input decoder and the output registers. It advances on a synchronous clock-enable (run/step), never a gated clock, so all state is on `clk`.

## Interface
- WIDTH, 16, maximum LFSR length in bits (≥ 2).
- LEN_W, $clog2(WIDTH+1), width of the length field.
- DEFAULT_TAPS, 16'hD008, reset tap mask (bits 15,14,12,3 = x^16+x^15+x^13+x^4+1).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_len  in  LEN_W  requested length L; sampled only on load.
- cfg_taps  in  WIDTH  tap mask; bit i = state bit i is a tap. Sampled only on load.
- cfg_galois  in  1  0 = Fibonacci, 1 = Galois. Sampled only on load.
- seed  in  WIDTH  initial state. Sampled only on load; masked to L bits.
- load  in  1  one-cycle or level; each cycle high reloads config and seed.
- run  in  1  level; advance every cycle while high.
- step  in  1  advance once per rising edge (0→1 between consecutive clk samples).
- value  out  WIDTH  current state, bits ≥ L forced 0.
- valid  out  1  config legal and state non-zero.
- wrap  out  1  one-cycle pulse when the state returns to the loaded seed.
- period  out  WIDTH  step count of the last completed cycle.
- period_valid  out  1  period holds a measured value.

## Operation
- Shadow registers len_r, taps_r, galois_r, seed_r are written only on load. Mid-run changes to the cfg_* inputs have no effect.
- Config is legal iff 2 ≤ len_r ≤ WIDTH and taps_r[len_r-1] = 1. Tap bits ≥ len_r are ignored.
- Fibonacci next state: {v[L-2:0], ^(v & taps_r)}.
- Galois next state: n[0] = v[L-1]; for 1 ≤ i < L, n[i] = v[i-1] ^ (v[L-1] & taps_r[i-1]).
- A given mask yields the same period in both modes.
- adv = run | (step & ~step_q), where step_q is step registered. adv is ignored while the config is illegal or the state is zero.
- States:
  - INVALID: illegal config or state = 0. value = 0, valid = 0, no advance, counter frozen. Left only via load with a legal config and a non-zero masked seed.
  - ACTIVE: valid = 1. On adv the state updates and cnt increments.
- Period counter cnt (WIDTH bits) saturates at all-ones.
  - If adv occurs and the next state equals seed_r: wrap = 1 next cycle, period = cnt+1 (saturating), period_valid = 1, cnt = 0.
- Load: state = seed & lenmask, cnt = 0, period_valid = 0, wrap = 0. Load overrides adv in the same cycle, and the step edge in that cycle is consumed.
- Reset values: value = 1, len_r = WIDTH, taps_r = DEFAULT_TAPS, galois_r = 0, seed_r = 1, valid = 1 (if DEFAULT_TAPS is legal), wrap = 0, period = 0, period_valid = 0, cnt = 0, step_q = 0.

## Timing
- Load in cycle N: value = masked seed at N+1; valid reflects the new config at N+1.
- adv in cycle N: value updates at N+1. wrap/period update in the same edge as the wrapping value.
- Step held high for k cycles produces exactly one advance. Step toggling every cycle advances on every rising edge.
- Load and step/run together: load wins; no advance that cycle.
- All outputs are registered. No combinational path from inputs to outputs.
- rst_n asserted mid-run: all registers take reset values immediately (async). The first advance can occur on the first clk edge after deassertion.

## Test plan
- Reset: assert rst_n low with run = 1 → value = 0x0001, valid = 1, wrap = 0, period_valid = 0. Hold these through release with run = 0.
- Fibonacci L = 4, taps = 0x000C, seed = 1, load then run → value sequence 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8,1. wrap pulses together with the final 1; period = 15, period_valid = 1.
- Galois, same config → sequence 1,2,4,8,9,…; wrap after 15 steps with period = 15. Default reset config, run → wrap after 65535 steps, period = 65535.
- Step: run = 0, step high for 5 cycles, then low, then high → exactly two advances (1→2→4). Load asserted on a step edge → value = seed, no advance.
- Invalid: load L = 8 with taps = 0x0040 → value = 0, valid = 0, run ignored. Load seed = 0 with a legal config → same result. Load a legal config → valid = 1 next cycle.
- Mid-run: change cfg_len without load → sequence unchanged. Pulse rst_n low mid-run → immediate reset values, cnt = 0.

Source files
------------

// File: rtl/lfsr_multimode_if.sv
// Configuration/stepping controls and state/period outputs of lfsr_multimode.
// The master side drives the controls; the slave side (the LFSR) returns the results.
interface lfsr_multimode_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH + 1)
);
  logic [LEN_W-1:0] cfg_len;
  logic [WIDTH-1:0] cfg_taps;
  logic             cfg_galois;
  logic [WIDTH-1:0] seed;
  logic             load;
  logic             run;
  logic             step;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             wrap;
  logic [WIDTH-1:0] period;
  logic             period_valid;

  modport master (
    output cfg_len, cfg_taps, cfg_galois, seed, load, run, step,
    input  value, valid, wrap, period, period_valid
  );

  modport slave (
    input  cfg_len, cfg_taps, cfg_galois, seed, load, run, step,
    output value, valid, wrap, period, period_valid
  );
endinterface

// File: rtl/lfsr_multimode.sv
// Runtime-configurable Fibonacci/Galois LFSR with seed load and period measurement.
// Advances on a clock enable (run level or step rising edge); all state is on clk.
module lfsr_multimode #(
  parameter int               WIDTH        = 16,
  parameter int               LEN_W        = $clog2(WIDTH + 1),
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = 16'hD008
) (
  input  logic            clk,
  input  logic            rst_n,
  lfsr_multimode_if.slave bus
);

  typedef enum logic {INVALID, ACTIVE} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(2);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam state_t           RST_STATE = DEFAULT_TAPS[WIDTH-1] ? ACTIVE : INVALID;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_r;
  logic [WIDTH-1:0] taps_r;
  logic             galois_r;
  logic [WIDTH-1:0] seed_r;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_q;
  logic             period_valid_q;
  logic             wrap_q;
  logic             step_q;

  logic [WIDTH-1:0] mask_r, mask_new, seed_masked, lfsr_next, cnt_inc;
  logic             new_top_tap, top_bit, fb, load_ok, adv, hit;

  always_comb begin
    mask_r      = '0;
    mask_new    = '0;
    new_top_tap = 1'b0;
    top_bit     = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      mask_r[i]   = LEN_W'(i) < len_r;
      mask_new[i] = LEN_W'(i) < bus.cfg_len;
      if (LEN_W'(i + 1) == bus.cfg_len) new_top_tap = bus.cfg_taps[i];
      if (LEN_W'(i + 1) == len_r)       top_bit     = lfsr_q[i];
    end

    // State bits at and above len_r are always zero, so taps there drop out of the parity.
    fb = ^(lfsr_q & taps_r);
    if (galois_r)
      lfsr_next = ({lfsr_q[WIDTH-2:0], top_bit}
                   ^ ({taps_r[WIDTH-2:0], 1'b0} & {WIDTH{top_bit}})) & mask_r;
    else
      lfsr_next = {lfsr_q[WIDTH-2:0], fb} & mask_r;

    seed_masked = bus.seed & mask_new;
    load_ok     = (bus.cfg_len >= LEN_MIN) && (bus.cfg_len <= LEN_MAX)
                  && new_top_tap && (seed_masked != '0);
    adv         = (state_q == ACTIVE) && (bus.run || (bus.step && !step_q));
    hit         = (lfsr_next == seed_r);
    cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + ONE;

    state_d = state_q;
    if (bus.load) state_d = load_ok ? ACTIVE : INVALID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r          <= LEN_MAX;
      taps_r         <= DEFAULT_TAPS;
      galois_r       <= 1'b0;
      seed_r         <= ONE;
      lfsr_q         <= ONE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
      step_q         <= 1'b0;
    end else begin
      step_q <= bus.step;
      wrap_q <= 1'b0;
      if (bus.load) begin
        len_r          <= bus.cfg_len;
        taps_r         <= bus.cfg_taps;
        galois_r       <= bus.cfg_galois;
        seed_r         <= seed_masked;
        lfsr_q         <= load_ok ? seed_masked : '0;
        cnt_q          <= '0;
        period_valid_q <= 1'b0;
      end else if (adv) begin
        lfsr_q <= lfsr_next;
        if (hit) begin
          wrap_q         <= 1'b1;
          period_q       <= cnt_inc;
          period_valid_q <= 1'b1;
          cnt_q          <= '0;
        end else begin
          cnt_q <= cnt_inc;
        end
      end
    end
  end

  assign bus.value        = lfsr_q;
  assign bus.valid        = (state_q == ACTIVE);
  assign bus.wrap         = wrap_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;

endmodule

// File: tb/tb_lfsr_multimode.sv
// Self-checking bench for lfsr_multimode: directed scenarios plus random stimulus,
// compared every cycle against an arithmetic reference model.
module tb_lfsr_multimode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  lfsr_multimode_if #(.WIDTH(16), .LEN_W(5)) bus ();

  lfsr_multimode #(.WIDTH(16), .LEN_W(5), .DEFAULT_TAPS(16'hD008)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model: integer arithmetic on the sequence rules.
  int m_len, m_taps, m_seed, m_val, m_cnt, m_per;
  bit m_gal, m_ok, m_wrap, m_pv, m_stepq;

  function automatic int lmask(int len);
    return (len >= 16) ? 'hFFFF : ((1 << len) - 1);
  endfunction

  function automatic bit legal(int len, int taps);
    return (len >= 2) && (len <= 16) && (((taps >> (len - 1)) & 1) == 1);
  endfunction

  function automatic int nxt(int v, int len, int taps, bit gal);
    int mask = lmask(len);
    int top  = (v >> (len - 1)) & 1;
    if (gal) return (top != 0) ? ((((v << 1) ^ (taps << 1)) | 1) & mask) : ((v << 1) & mask);
    return ((v << 1) | ($countones(v & taps) & 1)) & mask;
  endfunction

  function automatic int sat(int c);
    return (c >= 'hFFFF) ? 'hFFFF : c + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_len <= 16; m_taps <= 'hD008; m_gal <= 1'b0; m_seed <= 1; m_val <= 1;
      m_ok <= 1'b1; m_wrap <= 1'b0; m_per <= 0; m_pv <= 1'b0; m_cnt <= 0; m_stepq <= 1'b0;
    end else begin
      m_stepq <= bus.step;
      m_wrap  <= 1'b0;
      if (bus.load) begin
        m_len  <= int'(bus.cfg_len);
        m_taps <= int'(bus.cfg_taps);
        m_gal  <= bus.cfg_galois;
        m_seed <= int'(bus.seed) & lmask(int'(bus.cfg_len));
        m_ok   <= legal(int'(bus.cfg_len), int'(bus.cfg_taps))
                  && ((int'(bus.seed) & lmask(int'(bus.cfg_len))) != 0);
        m_val  <= (legal(int'(bus.cfg_len), int'(bus.cfg_taps))
                   && ((int'(bus.seed) & lmask(int'(bus.cfg_len))) != 0))
                  ? (int'(bus.seed) & lmask(int'(bus.cfg_len))) : 0;
        m_cnt  <= 0;
        m_pv   <= 1'b0;
      end else if (m_ok && (bus.run || (bus.step && !m_stepq))) begin
        m_val <= nxt(m_val, m_len, m_taps, m_gal);
        if (nxt(m_val, m_len, m_taps, m_gal) == m_seed) begin
          m_wrap <= 1'b1;
          m_per  <= sat(m_cnt);
          m_pv   <= 1'b1;
          m_cnt  <= 0;
        end else begin
          m_cnt <= sat(m_cnt);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_value", bus.value, m_val);
      chk("model_valid", bus.valid, m_ok);
      chk("model_wrap", bus.wrap, m_wrap);
      chk("model_period", bus.period, m_per);
      chk("model_period_valid", bus.period_valid, m_pv);
    end
  end

  task automatic do_load(input int len, input int taps, input bit gal, input int sd);
    @(negedge clk);
    bus.cfg_len = 5'(len); bus.cfg_taps = 16'(taps); bus.cfg_galois = gal;
    bus.seed = 16'(sd); bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic run_until_wrap(input int budget, output int steps);
    steps = 0;
    bus.run = 1'b1;
    do begin
      @(negedge clk);
      steps++;
    end while (!bus.wrap && steps < budget);
    bus.run = 1'b0;
  endtask

  int fib_seq[16] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
  int gal_seq[5]  = '{1, 2, 4, 8, 9};
  int steps;
  logic [15:0] rt;
  int rl;

  initial begin
    bus.cfg_len = '0; bus.cfg_taps = '0; bus.cfg_galois = 1'b0; bus.seed = '0;
    bus.load = 1'b0; bus.run = 1'b1; bus.step = 1'b0;
    cmp_en = 1'b1;

    // Reset held with run high, then released with run low.
    repeat (3) @(negedge clk);
    chk("rst_value", bus.value, 1);
    chk("rst_valid", bus.valid, 1);
    chk("rst_wrap", bus.wrap, 0);
    chk("rst_period_valid", bus.period_valid, 0);
    bus.run = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_hold_value", bus.value, 1);

    // Fibonacci L=4, taps 0xC.
    do_load(4, 'hC, 1'b0, 1);
    chk("fib_load_value", bus.value, 1);
    bus.run = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("fib_seq", bus.value, fib_seq[k]);
    end
    bus.run = 1'b0;
    chk("fib_wrap", bus.wrap, 1);
    chk("fib_period", bus.period, 15);
    chk("fib_period_valid", bus.period_valid, 1);

    // Galois, same mask.
    do_load(4, 'hC, 1'b1, 1);
    bus.run = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k < 5) chk("gal_seq", bus.value, gal_seq[k]);
    end
    bus.run = 1'b0;
    chk("gal_wrap", bus.wrap, 1);
    chk("gal_period", bus.period, 15);

    // Step edge detection: 5-cycle high, low, high -> two advances.
    do_load(4, 'hC, 1'b0, 1);
    bus.step = 1'b1;
    repeat (5) @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    chk("step_value", bus.value, 4);

    // Load coinciding with a step edge: load wins and the edge is consumed.
    bus.cfg_len = 5'd4; bus.cfg_taps = 16'hC; bus.cfg_galois = 1'b0; bus.seed = 16'd5;
    bus.load = 1'b1; bus.step = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("load_step_value", bus.value, 5);
    @(negedge clk);
    chk("load_step_hold", bus.value, 5);
    bus.step = 1'b0;

    // Illegal configs.
    do_load(8, 'h40, 1'b0, 1);
    chk("illegal_value", bus.value, 0);
    chk("illegal_valid", bus.valid, 0);
    bus.run = 1'b1;
    repeat (3) @(negedge clk);
    chk("illegal_run_value", bus.value, 0);
    bus.run = 1'b0;
    do_load(4, 'hC, 1'b0, 'h30);
    chk("zero_seed_valid", bus.valid, 0);
    do_load(4, 'hC, 1'b0, 1);
    chk("relegal_valid", bus.valid, 1);

    // cfg changes without load are ignored.
    bus.run = 1'b1;
    repeat (3) @(negedge clk);
    bus.cfg_len = 5'd7; bus.cfg_taps = 16'h0041; bus.cfg_galois = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrun_cfg_value", bus.value, fib_seq[5]);

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_value", bus.value, 1);
    chk("async_rst_valid", bus.valid, 1);
    chk("async_rst_period_valid", bus.period_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.run = 1'b0;

    // Random phase.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rl = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 6)) : int'($urandom_range(0, 20));
      rt = 16'($urandom);
      if (rl >= 1 && rl <= 16 && $urandom_range(0, 3) != 0) rt[rl - 1] = 1'b1;
      bus.cfg_len    = 5'(rl);
      bus.cfg_taps   = rt;
      bus.cfg_galois = 1'($urandom_range(0, 1));
      bus.seed       = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      bus.load       = ($urandom_range(0, 15) == 0);
      bus.run        = ($urandom_range(0, 2) == 0);
      bus.step       = 1'($urandom_range(0, 1));
    end

    // Default reset config: full 16-bit period.
    @(negedge clk);
    bus.load = 1'b0; bus.run = 1'b0; bus.step = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_until_wrap(70000, steps);
    chk("default_wrap_steps", steps, 65535);
    chk("default_period", bus.period, 65535);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
